// File: rtl/cmn_plru_array.sv
// cmn_plru_array: multi-set tree pseudo-LRU victim selector.
// Empty ways are preferred over the tree walk, and locked ways are never chosen.
module cmn_plru_array #(
  parameter int WAYS  = 4,
  parameter int SETS  = 16,
  parameter int SET_W = (SETS > 1) ? $clog2(SETS) : 1,
  parameter int WAY_W = $clog2(WAYS)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_touch_vld,
  input  logic [SET_W-1:0] i_touch_set,
  input  logic [WAYS-1:0]  i_touch_way,
  input  logic             i_req_vld,
  input  logic [SET_W-1:0] i_req_set,
  input  logic [WAYS-1:0]  i_req_valid,
  input  logic [WAYS-1:0]  i_req_lock,
  input  logic             i_req_alloc,
  output logic             o_rsp_vld,
  output logic [WAYS-1:0]  o_rsp_way_oh,
  output logic [WAY_W-1:0] o_rsp_way_idx,
  output logic             o_rsp_none
);
  logic [WAYS-2:0]  r_tree [SETS];
  logic             r_rsp_vld, r_rsp_none;
  logic [WAYS-1:0]  r_rsp_way_oh;
  logic [WAY_W-1:0] r_rsp_way_idx;
  logic [WAYS-2:0]  w_rd, w_alc_base;
  logic [WAYS-1:0]  w_cand, w_empty, w_vic_oh;
  logic [WAY_W-1:0] w_vic_idx, w_tch_idx;
  logic             w_none, w_tch, w_alc, w_same;

  // Marks every node on the way's root-to-leaf path: 1 when the way sits left.
  function automatic logic [WAYS-2:0] path_upd(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] w);
    logic [WAY_W-1:0] ww;
    int n;
    path_upd = t;
    ww = w;
    n = 0;
    for (int l = 0; l < WAY_W; l++) begin
      path_upd = ww[WAY_W-1] ? path_upd & ~((WAYS-1)'(1) << n) : path_upd | ((WAYS-1)'(1) << n);
      n = 2 * n + (ww[WAY_W-1] ? 2 : 1);
      ww = ww << 1;
    end
  endfunction

  assign w_rd    = r_tree[i_req_set];
  assign w_cand  = ~i_req_lock;
  assign w_empty = w_cand & ~i_req_valid;
  assign w_none  = ~|w_cand;
  assign w_vic_oh = w_none ? '0 : (WAYS'(1) << w_vic_idx);

  always_comb begin
    int n, base, half;
    logic [WAYS-1:0] m;
    logic go_r;
    n = 0;
    base = 0;
    for (int l = 0; l < WAY_W; l++) begin
      half = WAYS >> (l + 1);
      m = {WAYS{1'b1}} >> (WAYS - half);
      go_r = |(w_rd & ((WAYS-1)'(1) << n)) ? |((w_cand >> (base + half)) & m) : ~|((w_cand >> base) & m);
      base = base + (go_r ? half : 0);
      n = 2 * n + (go_r ? 2 : 1);
    end
    w_vic_idx = WAY_W'(base);
    for (int i = WAYS - 1; i >= 0; i--) if (w_empty[i]) w_vic_idx = WAY_W'(i);
    if (w_none) w_vic_idx = '0;
  end

  always_comb begin
    w_tch_idx = '0;
    for (int i = 0; i < WAYS; i++) if (i_touch_way[i]) w_tch_idx = WAY_W'(i);
  end

  assign w_tch = i_touch_vld & |i_touch_way;
  assign w_alc = i_req_vld & i_req_alloc & ~w_none;
  assign w_same = w_tch && (i_touch_set == i_req_set);
  // Same-set touch is folded in first so the alloc path wins on shared nodes.
  assign w_alc_base = w_same ? path_upd(w_rd, w_tch_idx) : w_rd;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_tree        <= '{default: '0};
      r_rsp_vld     <= 1'b0;
      r_rsp_none    <= 1'b0;
      r_rsp_way_oh  <= '0;
      r_rsp_way_idx <= '0;
    end else begin
      if (w_tch) r_tree[i_touch_set] <= path_upd(r_tree[i_touch_set], w_tch_idx);
      if (w_alc) r_tree[i_req_set] <= path_upd(w_alc_base, w_vic_idx);
      r_rsp_vld <= i_req_vld;
      if (i_req_vld) begin
        r_rsp_none    <= w_none;
        r_rsp_way_oh  <= w_vic_oh;
        r_rsp_way_idx <= w_vic_idx;
      end
    end
  end

  always_ff @(posedge i_clk)
    if (i_rst_n && i_touch_vld) assert ($onehot0(i_touch_way));

  assign o_rsp_vld     = r_rsp_vld;
  assign o_rsp_none    = r_rsp_none;
  assign o_rsp_way_oh  = r_rsp_way_oh;
  assign o_rsp_way_idx = r_rsp_way_idx;
endmodule

// File: tb/tb_cmn_plru_array.sv
// tb_cmn_plru_array: directed stimulus with a queue-based response scoreboard.
module tb_cmn_plru_array;
  localparam int WAYS = 4;
  localparam int SETS = 4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       touch_vld = 1'b0;
  logic [1:0] touch_set = '0;
  logic [3:0] touch_way = '0;
  logic       req_vld = 1'b0;
  logic [1:0] req_set = '0;
  logic [3:0] req_valid = 4'hF;
  logic [3:0] req_lock = '0;
  logic       req_alloc = 1'b0;
  logic       rsp_vld, rsp_none;
  logic [3:0] rsp_way_oh;
  logic [1:0] rsp_way_idx;
  logic       started = 1'b0;
  int checks = 0;
  int errors = 0;
  typedef struct packed {logic none; logic [1:0] idx;} exp_t;
  exp_t q[$];

  cmn_plru_array #(.WAYS(WAYS), .SETS(SETS)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_touch_vld(touch_vld), .i_touch_set(touch_set), .i_touch_way(touch_way),
    .i_req_vld(req_vld), .i_req_set(req_set), .i_req_valid(req_valid),
    .i_req_lock(req_lock), .i_req_alloc(req_alloc),
    .o_rsp_vld(rsp_vld), .o_rsp_way_oh(rsp_way_oh),
    .o_rsp_way_idx(rsp_way_idx), .o_rsp_none(rsp_none)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (started) begin
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rsp_vld", int'(rsp_vld), 1);
        chk("rsp_none", int'(rsp_none), int'(e.none));
        chk("rsp_way_idx", int'(rsp_way_idx), e.none ? 0 : int'(e.idx));
        chk("rsp_way_oh", int'(rsp_way_oh), e.none ? 0 : (1 << e.idx));
      end else chk("idle rsp_vld", int'(rsp_vld), 0);
    end
  end

  task automatic req(input int s, input logic [3:0] v, input logic [3:0] l, input bit a, input int idx, input bit none);
    req_vld = 1'b1; req_set = 2'(s); req_valid = v; req_lock = l; req_alloc = a;
    @(posedge clk);
    q.push_back(exp_t'{none: none, idx: 2'(idx)});
    #1;
    req_vld = 1'b0; req_alloc = 1'b0; req_valid = 4'hF; req_lock = '0;
  endtask

  task automatic rq(input int s, input int idx);
    req(s, 4'hF, 4'h0, 1'b0, idx, 1'b0);
  endtask

  task automatic touch(input int s, input logic [3:0] w);
    touch_vld = 1'b1; touch_set = 2'(s); touch_way = w;
    @(posedge clk); #1;
    touch_vld = 1'b0; touch_way = '0;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset rsp_vld", int'(rsp_vld), 0);
    chk("reset rsp_way_oh", int'(rsp_way_oh), 0);
    chk("reset rsp_way_idx", int'(rsp_way_idx), 0);
    chk("reset rsp_none", int'(rsp_none), 0);
    started = 1'b1;
    rq(0, 0);
    touch(1, 4'b0001);
    rq(1, 2);
    rq(0, 0);
    touch(2, 4'b0001); touch(2, 4'b0100); touch(2, 4'b0010);
    rq(2, 3);
    touch_vld = 1'b1; touch_set = 2'd2; touch_way = 4'b1000;
    rq(2, 3);
    touch_vld = 1'b0; touch_way = '0;
    rq(2, 0);
    req(3, 4'hF, 4'h0, 1'b1, 0, 1'b0);
    req(3, 4'hF, 4'h0, 1'b1, 2, 1'b0);
    req(3, 4'hF, 4'h0, 1'b1, 1, 1'b0);
    req(3, 4'hF, 4'h0, 1'b1, 3, 1'b0);
    touch(0, 4'b0001);
    req(0, 4'b1011, 4'h0, 1'b0, 2, 1'b0);
    req(0, 4'hF, 4'b0100, 1'b0, 3, 1'b0);
    req(0, 4'hF, 4'b1100, 1'b0, 1, 1'b0);
    req(0, 4'b0101, 4'h0, 1'b0, 1, 1'b0);
    req(0, 4'hF, 4'hF, 1'b1, 0, 1'b1);
    rq(0, 2);
    touch(1, 4'b0000);
    rq(1, 2);
    touch_vld = 1'b1; touch_set = 2'd1; touch_way = 4'b0010;
    req(1, 4'hF, 4'h0, 1'b1, 2, 1'b0);
    touch_vld = 1'b0; touch_way = '0;
    rq(1, 0);
    req(0, 4'hF, 4'b0111, 1'b0, 3, 1'b0);
    rst_n = 1'b0; req_vld = 1'b1; req_set = 2'd1;
    @(posedge clk); #1;
    req_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post-reset rsp_way_oh", int'(rsp_way_oh), 0);
    chk("post-reset rsp_way_idx", int'(rsp_way_idx), 0);
    chk("post-reset rsp_none", int'(rsp_none), 0);
    for (int s = 0; s < SETS; s++) rq(s, 0);
    repeat (3) @(posedge clk);
    chk("pending responses", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmn_plru_array.md
# cmn_plru_array

Multi-set tree pseudo-LRU replacement engine. It keeps one binary-tree PLRU state per set for `SETS` sets of `WAYS` ways, and returns a registered victim way one cycle after a request. Victim selection prefers invalid ways and never returns a locked way. It sits beside set-associative structures in the cmn library (caches, TLBs, predictor tables) and replaces the single-set, matrix-output PLRU where many sets share one allocator.

## Interface
- `WAYS`, 4: ways per set; power of 2, ≥2
- `SETS`, 16: number of sets; ≥1
- `SET_W`, `$clog2(SETS)` (1 if `SETS`==1): set index width
- `WAY_W`, `$clog2(WAYS)`: way index width

- `clk`  in  1  single clock; all state updates on its rising edge
- `rst_n`  in  1  reset, synchronous, active-low
- `touch_vld`  in  1  hit/usage update strobe
- `touch_set`  in  `SET_W`  set being touched
- `touch_way`  in  `WAYS`  one-hot way touched; all-zero means no update
- `req_vld`  in  1  victim request
- `req_set`  in  `SET_W`  set for victim lookup
- `req_valid`  in  `WAYS`  per-way valid bits of the set (0 = empty)
- `req_lock`  in  `WAYS`  per-way lock; a locked way is never returned
- `req_alloc`  in  1  with `req_vld`: also mark the chosen victim as most-recently-used
- `rsp_vld`  out  1  response valid, one cycle after `req_vld`
- `rsp_way_oh`  out  `WAYS`  one-hot victim; zero when `rsp_none`
- `rsp_way_idx`  out  `WAY_W`  encoded victim; 0 when `rsp_none`
- `rsp_none`  out  1  every way was locked; no victim

## Operation
- Per set: `WAYS-1` node bits, heap-numbered. Node 0 is the root. Node n has children 2n+1 (left) and 2n+2 (right). Leaf-level node `WAYS/2-1+p` covers ways 2p and 2p+1.
- Node bit 1 means the left subtree was used more recently, so the victim walk goes right. Bit 0 sends the walk left.
- Touch of way w updates every node on w's root-to-leaf path. The bit is set to 1 if w lies in that node's left subtree, otherwise 0. Nodes off the path are unchanged.
- Victim selection is evaluated combinationally from the stored state of `req_set`:
  1. Candidate mask = `~req_lock`.
  2. If any candidate has `req_valid`=0, the victim is the lowest-index such way. The tree is ignored.
  3. Otherwise walk from the root. At each node take the child the node bit prefers, unless that subtree has no candidate; in that case take the other child.
  4. If the candidate mask is zero, `rsp_none`=1.
- `req_alloc`=1 with `rsp_none`=0: the chosen victim is touched in set `req_set`. This uses the same path-update rule as a touch.
- Touch and alloc-update in the same cycle:
  - Different sets: both apply.
  - Same set: both paths apply; on nodes common to both paths the alloc value wins.
- `req_vld`=0: `req_alloc` is ignored and no response is produced.

## Timing
- Request sampled in cycle T reads state as committed at the end of T-1. A same-cycle touch is not forwarded.
- `rsp_*` are registered and valid in T+1 while `rsp_vld`=1. Back-to-back requests give back-to-back responses; one request per cycle.
- Touch and alloc state updates commit at the end of the cycle in which they are sampled. A request in T+1 sees them.
- Values held while `rsp_vld`=0:
  - `rsp_way_oh`, `rsp_way_idx`, `rsp_none` hold their last response value.
  - After reset they are all 0.
- Reset (`rst_n`=0 at a clock edge):
  - All node bits of all sets clear to 0, so the victim is way 0 for a fully valid, unlocked set.
  - `rsp_vld`=0, `rsp_way_oh`=0, `rsp_way_idx`=0, `rsp_none`=0.
  - Any request sampled in the reset cycle is dropped; no response follows.
- `touch_way` with more than one bit set is illegal. Assert it in simulation; the behaviour is unspecified.

## Test plan
All scenarios use `WAYS`=4 and `SETS`=4, with every way valid and unlocked unless stated.
- Reset, then request set 0 → T+1: `rsp_vld`=1, `rsp_way_idx`=0, `rsp_way_oh`=4'b0001, `rsp_none`=0.
- Touch way 0 in set 1, then request set 1 → victim 2. A following request to set 0 → victim 0, which shows sets are independent.
- From reset, touch ways 0, 2, 1 in set 2, then request set 2 → victim 3. Same-cycle touch and request on set 2 → response reflects the pre-touch state.
- Alloc sequence: four consecutive `req_vld`+`req_alloc` on set 3 from reset → victims 0, 2, 1, 3, with `rsp_vld` high on four consecutive cycles.
- Masks, after touching way 0 in set 0:
  - `req_valid`=4'b1011 → victim 2.
  - `req_lock`=4'b0100 → victim 3.
  - `req_lock`=4'b1111 → `rsp_none`=1, `rsp_way_oh`=0; state is unchanged even with `req_alloc`=1.
- Reset asserted mid-stream while a request is in flight → no response follows; all sets return victim 0.
